// File: rtl/ps2_calc_core.sv
// ps2_calc_core -- multi-digit decimal calculator core.
//
// Takes decoded PS/2 set-2 key-release events, keeps two binary operands (A, B)
// and an operator, computes + - x / over a multi-cycle datapath, and shows the
// operand being typed (or the result) as packed BCD for 7-segment decoders.
//
// Optional build macro: CALC_DIV_EN -- when defined, key 4A selects divide and
// the restoring divider is built; when undefined, 4A is an unknown key.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-low reset
//   key_valid  one-cycle strobe, key_code holds a newly released key
//   key_code   PS/2 set-2 scancode
//   bcd_out    packed BCD display value, digit 0 in bits [3:0]
//   neg        displayed result is negative (magnitude on bcd_out)
//   err        error latched (overflow, divide by zero, illegal chain)
//   busy       computing/converting; incoming keys are dropped
module ps2_calc_core #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                key_valid,
  input  logic [7:0]          key_code,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic                neg,
  output logic                err,
  output logic                busy
);

  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  localparam longint unsigned MAXV_L = pow10(DIGITS) - 1;
  localparam longint unsigned LIMV_L = pow10(DIGITS - 1);
  localparam int              W      = $clog2(MAXV_L + 1);
  localparam int              CW     = $clog2(W + 1);
  localparam logic [W-1:0]    MAXV   = MAXV_L[W-1:0];
  // An operand below LIMV has fewer than DIGITS significant digits.
  localparam logic [W-1:0]    LIMV   = LIMV_L[W-1:0];
  localparam logic [CW-1:0]   CNT_W  = CW'(W);

  typedef enum logic [2:0] {ENTER_A, ENTER_B, CALC, CONV, RESULT, ERROR} state_t;
  typedef enum logic [2:0] {OP_NONE, OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_t;

  state_t              state_reg, state_next, ret_reg, ret_next;
  op_t                 op_reg, op_next, key_op;
  logic [W-1:0]        a_reg, a_next, b_reg, b_next, bin_reg, bin_next;
  logic [CW-1:0]       cnt_reg, cnt_next;
  logic [4*DIGITS-1:0] bcd_reg, bcd_next, bcd_out_reg, bcd_out_next;
  logic                neg_reg, neg_next, res_neg_reg, res_neg_next;

  logic                is_digit, is_op, is_eq, is_clr, is_bksp, accept;
  logic [3:0]          key_digit;
  logic [W-1:0]        opnd, edit_val, calc_res;
  logic                calc_neg, calc_fail, calc_done;
  logic [W:0]          sum_w;
  logic [2*W-1:0]      prod;
  logic [4*DIGITS-2:0] bcd_adj;

  assign sum_w = {1'b0, a_reg} + {1'b0, b_reg};
  assign prod  = (2*W)'(a_reg) * (2*W)'(b_reg);

`ifdef CALC_DIV_EN
  logic [W-1:0] rem_reg, rem_next, quo_reg, quo_next, div_diff;
  logic [W:0]   div_trial;
  logic         div_ge;
  // Restoring step: bring down the next dividend bit, subtract B if it fits.
  // When it fits the true difference is below B, so W bits hold it exactly.
  assign div_trial = {rem_reg, quo_reg[W-1]};
  assign div_ge    = div_trial >= {1'b0, b_reg};
  assign div_diff  = div_trial[W-1:0] - b_reg;
`endif

  // Double-dabble add-3 stage. The top digit only keeps 3 bits: its MSB would
  // be shifted out, which never happens for values up to MAXV.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      if (gi < DIGITS - 1) begin : g_full
        assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                    bcd_reg[4*gi +: 4] + 4'd3 : bcd_reg[4*gi +: 4];
      end else begin : g_top
        assign bcd_adj[4*gi +: 3] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                    bcd_reg[4*gi +: 3] + 3'd3 : bcd_reg[4*gi +: 3];
      end
    end
  endgenerate

  // Key decode
  always_comb begin
    is_digit  = 1'b0;
    key_digit = 4'd0;
    is_op     = 1'b0;
    key_op    = OP_NONE;
    is_eq     = 1'b0;
    is_clr    = 1'b0;
    is_bksp   = 1'b0;
    case (key_code)
      8'h45: begin is_digit = 1'b1; key_digit = 4'd0; end
      8'h16: begin is_digit = 1'b1; key_digit = 4'd1; end
      8'h1E: begin is_digit = 1'b1; key_digit = 4'd2; end
      8'h26: begin is_digit = 1'b1; key_digit = 4'd3; end
      8'h25: begin is_digit = 1'b1; key_digit = 4'd4; end
      8'h2E: begin is_digit = 1'b1; key_digit = 4'd5; end
      8'h36: begin is_digit = 1'b1; key_digit = 4'd6; end
      8'h3D: begin is_digit = 1'b1; key_digit = 4'd7; end
      8'h3E: begin is_digit = 1'b1; key_digit = 4'd8; end
      8'h46: begin is_digit = 1'b1; key_digit = 4'd9; end
      8'h79: begin is_op = 1'b1; key_op = OP_ADD; end
      8'h7B: begin is_op = 1'b1; key_op = OP_SUB; end
      8'h7C: begin is_op = 1'b1; key_op = OP_MUL; end
`ifdef CALC_DIV_EN
      8'h4A: begin is_op = 1'b1; key_op = OP_DIV; end
`endif
      8'h5A: is_eq   = 1'b1;
      8'h76: is_clr  = 1'b1;
      8'h66: is_bksp = 1'b1;
      default: ;
    endcase
  end

  // Next-state and outputs
  always_comb begin
    state_next   = state_reg;
    ret_next     = ret_reg;
    op_next      = op_reg;
    a_next       = a_reg;
    b_next       = b_reg;
    bin_next     = bin_reg;
    cnt_next     = cnt_reg;
    bcd_next     = bcd_reg;
    bcd_out_next = bcd_out_reg;
    neg_next     = neg_reg;
    res_neg_next = res_neg_reg;
`ifdef CALC_DIV_EN
    rem_next     = rem_reg;
    quo_next     = quo_reg;
`endif
    edit_val     = '0;
    calc_res     = '0;
    calc_neg     = 1'b0;
    calc_fail    = 1'b0;
    calc_done    = 1'b0;
    busy         = (state_reg == CALC) || (state_reg == CONV);
    err          = (state_reg == ERROR);
    accept       = key_valid && !busy;
    opnd         = (state_reg == ENTER_B) ? b_reg : a_reg;

    if (accept && is_clr) begin
      state_next   = ENTER_A;
      ret_next     = ENTER_A;
      op_next      = OP_NONE;
      a_next       = '0;
      b_next       = '0;
      bin_next     = '0;
      cnt_next     = '0;
      bcd_next     = '0;
      bcd_out_next = '0;
      neg_next     = 1'b0;
      res_neg_next = 1'b0;
    end else begin
      case (state_reg)
        ENTER_A, ENTER_B: begin
          if (accept) begin
            if ((is_digit && opnd < LIMV) || is_bksp) begin
              edit_val = is_digit ? opnd * W'(10) + W'(key_digit) : opnd / W'(10);
              if (state_reg == ENTER_A) a_next = edit_val;
              else                      b_next = edit_val;
              bin_next   = edit_val;
              bcd_next   = '0;
              cnt_next   = '0;
              ret_next   = state_reg;
              state_next = CONV;
            end else if (is_op) begin
              op_next = key_op;
              if (state_reg == ENTER_A) begin
                b_next     = '0;
                state_next = ENTER_B;
              end
            end else if (is_eq && state_reg == ENTER_B) begin
              cnt_next   = '0;
`ifdef CALC_DIV_EN
              rem_next   = '0;
              quo_next   = a_reg;
`endif
              state_next = CALC;
            end
          end
        end
        CALC: begin
          case (op_reg)
            OP_ADD: begin
              calc_done = 1'b1;
              calc_fail = sum_w > {1'b0, MAXV};
              calc_res  = sum_w[W-1:0];
            end
            OP_SUB: begin
              calc_done = 1'b1;
              if (a_reg >= b_reg) begin
                calc_res = a_reg - b_reg;
              end else begin
                calc_res = b_reg - a_reg;
                calc_neg = 1'b1;
              end
            end
            OP_MUL: begin
              calc_done = 1'b1;
              calc_fail = prod > (2*W)'(MAXV);
              calc_res  = prod[W-1:0];
            end
`ifdef CALC_DIV_EN
            OP_DIV: begin
              if (cnt_reg == '0 && b_reg == '0) begin
                calc_fail = 1'b1;
              end else begin
                rem_next = div_ge ? div_diff : div_trial[W-1:0];
                quo_next = {quo_reg[W-2:0], div_ge};
                cnt_next = cnt_reg + CW'(1);
                if (cnt_reg == CW'(W - 1)) begin
                  calc_done = 1'b1;
                  calc_res  = {quo_reg[W-2:0], div_ge};
                end
              end
            end
`endif
            default: calc_fail = 1'b1;
          endcase
          if (calc_fail) begin
            state_next   = ERROR;
            bcd_out_next = '0;
            neg_next     = 1'b0;
          end else if (calc_done) begin
            a_next       = calc_res;
            res_neg_next = calc_neg;
            bin_next     = calc_res;
            bcd_next     = '0;
            cnt_next     = '0;
            ret_next     = RESULT;
            state_next   = CONV;
          end
        end
        CONV: begin
          // W shift cycles, then one cycle to publish the BCD value.
          if (cnt_reg != CNT_W) begin
            bin_next = {bin_reg[W-2:0], 1'b0};
            bcd_next = {bcd_adj, bin_reg[W-1]};
            cnt_next = cnt_reg + CW'(1);
          end else begin
            bcd_out_next = bcd_reg;
            neg_next     = (ret_reg == RESULT) ? res_neg_reg : 1'b0;
            state_next   = ret_reg;
          end
        end
        RESULT: begin
          if (accept) begin
            if (is_op) begin
              if (neg_reg) begin
                // A negative result cannot seed a chain.
                state_next   = ERROR;
                bcd_out_next = '0;
                neg_next     = 1'b0;
              end else begin
                op_next    = key_op;
                b_next     = '0;
                state_next = ENTER_B;
              end
            end else if (is_digit) begin
              a_next     = W'(key_digit);
              neg_next   = 1'b0;
              bin_next   = W'(key_digit);
              bcd_next   = '0;
              cnt_next   = '0;
              ret_next   = ENTER_A;
              state_next = CONV;
            end else if (is_eq) begin
              cnt_next   = '0;
`ifdef CALC_DIV_EN
              rem_next   = '0;
              quo_next   = a_reg;
`endif
              state_next = CALC;
            end
          end
        end
        ERROR: ;
        default: state_next = ENTER_A;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg   <= ENTER_A;
      ret_reg     <= ENTER_A;
      op_reg      <= OP_NONE;
      a_reg       <= '0;
      b_reg       <= '0;
      bin_reg     <= '0;
      cnt_reg     <= '0;
      bcd_reg     <= '0;
      bcd_out_reg <= '0;
      neg_reg     <= 1'b0;
      res_neg_reg <= 1'b0;
`ifdef CALC_DIV_EN
      rem_reg     <= '0;
      quo_reg     <= '0;
`endif
    end else begin
      state_reg   <= state_next;
      ret_reg     <= ret_next;
      op_reg      <= op_next;
      a_reg       <= a_next;
      b_reg       <= b_next;
      bin_reg     <= bin_next;
      cnt_reg     <= cnt_next;
      bcd_reg     <= bcd_next;
      bcd_out_reg <= bcd_out_next;
      neg_reg     <= neg_next;
      res_neg_reg <= res_neg_next;
`ifdef CALC_DIV_EN
      rem_reg     <= rem_next;
      quo_reg     <= quo_next;
`endif
    end
  end

  assign bcd_out = bcd_out_reg;
  assign neg     = neg_reg;

endmodule

// File: tb/tb_ps2_calc_core.sv
// tb_ps2_calc_core -- directed self-checking bench for ps2_calc_core (DIGITS=4).
// Keys are driven on the falling edge for one cycle; outputs are sampled on
// falling edges. Division checks depend on whether CALC_DIV_EN is defined.
module tb_ps2_calc_core;

  localparam int DIGITS = 4;

  localparam logic [7:0] K0 = 8'h45, K1 = 8'h16, K2 = 8'h1E, K3 = 8'h26, K4 = 8'h25;
  localparam logic [7:0] K5 = 8'h2E, K7 = 8'h3D, K8 = 8'h3E, K9 = 8'h46;
  localparam logic [7:0] KADD = 8'h79, KSUB = 8'h7B, KMUL = 8'h7C, KDIV = 8'h4A;
  localparam logic [7:0] KEQ = 8'h5A, KESC = 8'h76, KBS = 8'h66;

  logic                clk = 1'b0;
  logic                reset;
  logic                key_valid;
  logic [7:0]          key_code;
  logic [4*DIGITS-1:0] bcd_out;
  logic                neg, err, busy;

  int n_cmp = 0;
  int n_bad = 0;
  int lat   = 0;

  always #5 clk = ~clk;

  ps2_calc_core #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .reset     (reset),
    .key_valid (key_valid),
    .key_code  (key_code),
    .bcd_out   (bcd_out),
    .neg       (neg),
    .err       (err),
    .busy      (busy)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Present a key for one cycle; returns right after the accepting edge.
  task automatic push_key(input logic [7:0] code);
    @(negedge clk);
    key_code  = code;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  // Count cycles until busy drops, bounded.
  task automatic wait_idle();
    lat = 0;
    while (busy && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (busy) check_val("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic send_key(input logic [7:0] code);
    push_key(code);
    wait_idle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset     = 1'b0;
    key_valid = 1'b0;
    key_code  = 8'h00;
    repeat (3) @(negedge clk);
    check_val("rst_bcd", 32'(bcd_out), 32'h0);
    check_val("rst_neg", 32'(neg), 32'd0);
    check_val("rst_err", 32'(err), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;

    // 12 + 34 = 46
    send_key(K1);
    check_val("digit_latency", 32'(lat), 32'd15);
    check_val("disp_1", 32'(bcd_out), 32'h0001);
    send_key(K2);
    send_key(KADD);
    send_key(K3);
    send_key(K4);
    check_val("disp_b_34", 32'(bcd_out), 32'h0034);
    send_key(KEQ);
    check_val("add_latency", 32'(lat), 32'd16);
    check_val("add_bcd", 32'(bcd_out), 32'h0046);
    check_val("add_neg", 32'(neg), 32'd0);
    check_val("add_err", 32'(err), 32'd0);

    // Chain on result, then repeat with '='
    send_key(KADD);
    send_key(K5);
    check_val("chain_b", 32'(bcd_out), 32'h0005);
    send_key(KEQ);
    check_val("chain_sum", 32'(bcd_out), 32'h0051);
    send_key(KEQ);
    check_val("repeat_eq", 32'(bcd_out), 32'h0056);

    // 9999 * 2 overflows
    send_key(KESC);
    check_val("clr_bcd", 32'(bcd_out), 32'h0);
    send_key(K9); send_key(K9); send_key(K9); send_key(K9);
    send_key(KMUL);
    send_key(K2);
    send_key(KEQ);
    check_val("mul_ovf_latency", 32'(lat), 32'd1);
    check_val("mul_ovf_err", 32'(err), 32'd1);
    check_val("mul_ovf_bcd", 32'(bcd_out), 32'h0);
    send_key(K3);
    check_val("err_ignores_digit", 32'(err), 32'd1);
    send_key(KESC);
    check_val("esc_err", 32'(err), 32'd0);
    check_val("esc_bcd", 32'(bcd_out), 32'h0);
    send_key(K3);
    send_key(KEQ);
    check_val("enter_a_eq_ignored_lat", 32'(lat), 32'd0);
    check_val("enter_a_eq_ignored_bcd", 32'(bcd_out), 32'h0003);

    // Division
    send_key(KESC);
`ifdef CALC_DIV_EN
    send_key(K7); send_key(KDIV); send_key(K0); send_key(KEQ);
    check_val("div0_latency", 32'(lat), 32'd1);
    check_val("div0_err", 32'(err), 32'd1);
    send_key(KESC);
    send_key(K9); send_key(K9); send_key(KDIV); send_key(K7); send_key(KEQ);
    check_val("div_latency", 32'(lat), 32'd29);
    check_val("div_bcd", 32'(bcd_out), 32'h0014);
    check_val("div_err", 32'(err), 32'd0);
`else
    send_key(K9); send_key(K9); send_key(KDIV); send_key(K7);
    check_val("nodiv_bcd", 32'(bcd_out), 32'h0997);
    send_key(KEQ);
    check_val("nodiv_eq_lat", 32'(lat), 32'd0);
    check_val("nodiv_err", 32'(err), 32'd0);
`endif

    // 5 - 8 = -3, then operator on negative result
    send_key(KESC);
    send_key(K5); send_key(KSUB); send_key(K8); send_key(KEQ);
    check_val("sub_latency", 32'(lat), 32'd16);
    check_val("sub_bcd", 32'(bcd_out), 32'h0003);
    check_val("sub_neg", 32'(neg), 32'd1);
    send_key(KADD);
    check_val("neg_chain_err", 32'(err), 32'd1);
    check_val("neg_chain_neg", 32'(neg), 32'd0);

    // 8 - 5 = 3, positive
    send_key(KESC);
    send_key(K8); send_key(KSUB); send_key(K5); send_key(KEQ);
    check_val("sub_pos_bcd", 32'(bcd_out), 32'h0003);
    check_val("sub_pos_neg", 32'(neg), 32'd0);

    // Digit limit and backspace
    send_key(KESC);
    send_key(K1); send_key(K2); send_key(K3); send_key(K4);
    send_key(K5);
    check_val("fifth_digit_lat", 32'(lat), 32'd0);
    check_val("fifth_digit_bcd", 32'(bcd_out), 32'h1234);
    send_key(KBS);
    check_val("bksp_bcd", 32'(bcd_out), 32'h0123);

    // Keys while busy are dropped
    send_key(KESC);
    send_key(K1); send_key(KADD); send_key(K2);
    push_key(KEQ);
    check_val("busy_after_eq", 32'(busy), 32'd1);
    push_key(KESC);
    push_key(K9);
    wait_idle();
    check_val("busy_drop_bcd", 32'(bcd_out), 32'h0003);
    check_val("busy_drop_err", 32'(err), 32'd0);

    // Reset during conversion aborts it
    send_key(KESC);
    send_key(K4); send_key(KADD); send_key(K5);
    check_val("pre_abort_bcd", 32'(bcd_out), 32'h0005);
    push_key(KEQ);
    repeat (5) @(negedge clk);
    check_val("mid_conv_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check_val("abort_bcd", 32'(bcd_out), 32'h0);
    check_val("abort_busy", 32'(busy), 32'd0);
    repeat (20) @(negedge clk);
    check_val("abort_no_result", 32'(bcd_out), 32'h0);
    send_key(K7);
    check_val("after_abort_digit", 32'(bcd_out), 32'h0007);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ps2_calc_core.md
Name: ps2_calc_core

Overview:
Multi-digit decimal calculator core with a parametrised digit count.
- Consumes decoded key-release events, i.e. one 8-bit scancode plus a one-cycle valid strobe from the team's PS/2 receiver.
- Holds two binary operands and an operator, and computes +, −, ×, ÷ over a multi-cycle datapath.
- Presents the active operand or the result as packed BCD for the 7-segment drivers.
- Sits between the PS/2 receiver and the per-digit BCD-to-7-segment decoders.

Parameters:
- DIGITS, 4, number of decimal digits displayed and accepted per operand (1..8).
- W, derived localparam, not overridable: bits needed to hold 10^DIGITS−1 (DIGITS=4 → W=14).
- MAXV, derived localparam: 10^DIGITS−1.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- key_valid  in  1  one-cycle strobe: key_code holds a newly released key.
- key_code  in  8  PS/2 set-2 scancode.
- bcd_out  out  4*DIGITS  packed BCD display value, digit 0 in bits [3:0], leading zeros shown as 0.
- neg  out  1  displayed result is negative (magnitude on bcd_out).
- err  out  1  error latched (overflow, divide by zero, illegal chain).
- busy  out  1  datapath computing/converting; keys dropped.

Behaviour:
- Reset: when reset=0 at a clk edge, all state clears.
  - bcd_out=0, neg=0, err=0, busy=0.
  - A=0, B=0, op=none, state=ENTER_A.
  - Reset mid-computation aborts it with no further output change.
- Key map:
  - Digits 0–9 use 45,16,1E,26,25,2E,36,3D,3E,46.
  - Operators: + 79, − 7B, × 7C, ÷ 4A.
  - = is 5A (Enter), CLR is 76 (Esc), BKSP is 66.
  - Any other code is ignored.
- Key acceptance: a key is accepted only when key_valid=1 and busy=0. When busy=1 the key is dropped, with no queueing.
- States: ENTER_A, ENTER_B, CALC, CONV, RESULT, ERROR.
- ENTER_A:
  - Digit d → A=A*10+d, but only while A has fewer than DIGITS significant digits; otherwise ignored.
  - BKSP → A=A/10.
  - Operator → latch op, B=0, go to ENTER_B.
  - = is ignored.
- ENTER_B:
  - Digits and BKSP act on B the same way they act on A.
  - Operator → replace op.
  - = → CALC.
- CALC (busy=1):
  - + and − take 1 cycle.
  - × takes 1 cycle with a 2W-bit product.
  - ÷ is restoring division, one quotient bit per cycle: W cycles, truncating.
  - Overflow: result > MAXV → ERROR.
  - Divide by zero (B=0): ERROR on the first CALC cycle.
  - Subtraction with A<B: magnitude B−A, neg=1.
- CONV (busy=1): sequential double-dabble, one bit per cycle, W cycles. Then bcd_out is updated, A=result magnitude, and state goes to RESULT.
- Latency from accepting = to bcd_out valid and busy=0:
  - + − ×: 1+W+1 cycles (16 at DIGITS=4).
  - ÷: W+W+1 cycles (29).
- Operand BCD: in ENTER_A/ENTER_B each digit or BKSP also passes through CONV. The displayed operand updates W+1 cycles after the key, with busy asserted meanwhile.
- RESULT:
  - Operator with neg=0 → chain: A=result, go to ENTER_B.
  - Operator with neg=1 → ERROR.
  - Digit → A=d, neg=0, go to ENTER_A.
  - = → repeat the last op with the same B.
- ERROR:
  - err=1, bcd_out=0, neg=0.
  - Only CLR leaves this state.
- CLR in any non-busy state gives the same result as reset, except it takes effect only on an accepted key.

Optional Feature:
CALC_DIV_EN
- Defined: ÷ key supported as above.
- Undefined: the divider datapath is not built and 4A is treated as an unknown code (ignored). Worst-case latency is W+2.

Test Plan:
- DIGITS=4; keys 1,2,+,3,4,= → after 16 cycles bcd_out=16'h0046, neg=0, err=0, busy=0.
- Keys 9,9,9,9,*,2,= → err=1, bcd_out=0; then Esc → err=0, bcd_out=0, state ENTER_A.
- Keys 7,÷,0,= → err=1. Keys 9,9,÷,7,= → bcd_out=16'h0014 after 29 cycles (CALC_DIV_EN defined).
- Keys 5,−,8,= → neg=1, bcd_out=16'h0003. Then + → err=1.
- Keys 1,2,3,4,5 → bcd_out=16'h1234 (fifth digit ignored). BKSP → 16'h0123.
- Send a key while busy=1 → key ignored. Assert reset=0 mid-CONV → next cycle bcd_out=0, busy=0; result never appears.
